// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program-counter sequencer. Holds the PC register and selects
//                its next value from a sequential step, an absolute jump, a
//                signed relative branch, or call/return through a small
//                internal LIFO return-address stack.
//  Revision    : 1.0 - initial parametrised release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH      PC / address width in bits (2..32)
//    STEP       sequential increment added to the PC
//    RESET_VEC  PC value loaded on reset
//    DEPTH      return-stack entries (power of two, 2..16)
//  Ports
//    clk        in   rising-edge clock
//    reset      in   asynchronous active-high reset, clears all state
//    enable     in   1 = PC may advance; 0 = stall, everything holds
//    jumpEn     in   absolute jump to jumpAddr
//    jumpAddr   in   absolute target (also the call target)
//    branchEn   in   relative branch by branchOff
//    branchOff  in   two's-complement offset added to pcCount
//    callEn     in   push pcCount+STEP, jump to jumpAddr
//    retEn      in   pop return address into PC
//    pcCount    out  current PC (registered)
//    pcPlusStep out  pcCount + STEP (combinational)
//    stackDepth out  number of valid return-stack entries
//    overflow   out  sticky: call issued with the stack full
//    underflow  out  sticky: return issued with the stack empty
//    wrapped    out  one-cycle pulse after a step that carried out
//  Command priority when enable=1: retEn > callEn > jumpEn > branchEn > step
// ============================================================================
module pc_sequencer #(
  parameter int WIDTH     = 8,
  parameter int STEP      = 1,
  parameter int RESET_VEC = 0,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     jumpEn,
  input  logic [WIDTH-1:0]         jumpAddr,
  input  logic                     branchEn,
  input  logic [WIDTH-1:0]         branchOff,
  input  logic                     callEn,
  input  logic                     retEn,
  output logic [WIDTH-1:0]         pcCount,
  output logic [WIDTH-1:0]         pcPlusStep,
  output logic [$clog2(DEPTH):0]   stackDepth,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     wrapped
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int               c_PTR_W     = $clog2(DEPTH);
  localparam int               c_CNT_W     = c_PTR_W + 1;
  localparam logic [WIDTH-1:0] c_STEP      = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] c_RESET_VEC = WIDTH'(RESET_VEC);
  localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]   r_pc;
  logic [c_CNT_W-1:0] r_depth;
  logic               r_overflow;
  logic               r_underflow;
  logic               r_wrapped;
  // Stack contents are not reset: only entries below r_depth are ever read.
  logic [WIDTH-1:0]   r_stack [DEPTH];

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // One extra bit on the step sum so the carry-out can drive the wrap pulse.
  logic [WIDTH:0]       w_sum;
  logic [WIDTH-1:0]     w_branchTarget;
  logic                 w_empty;
  logic                 w_full;
  logic [c_PTR_W-1:0]   w_topIdx;
  logic [c_PTR_W-1:0]   w_pushIdx;
  logic [WIDTH-1:0]     w_pcNext;
  logic [c_CNT_W-1:0]   w_depthNext;
  logic                 w_push;
  logic                 w_setOverflow;
  logic                 w_setUnderflow;
  logic                 w_wrapNext;

  assign w_sum          = {1'b0, r_pc} + {1'b0, c_STEP};
  assign w_branchTarget = r_pc + branchOff;   // carry discarded: modulo 2^WIDTH
  assign w_empty        = (r_depth == '0);
  assign w_full         = (r_depth == c_FULL);
  // Top-of-stack is one below the fill count; the push slot is the fill count
  // itself. Truncation is safe: pushIdx is only used when not full and topIdx
  // only when not empty.
  assign w_topIdx       = c_PTR_W'(r_depth - 1'b1);
  assign w_pushIdx      = c_PTR_W'(r_depth);

  always_comb begin
    w_pcNext       = r_pc;
    w_depthNext    = r_depth;
    w_push         = 1'b0;
    w_setOverflow  = 1'b0;
    w_setUnderflow = 1'b0;
    w_wrapNext     = 1'b0;

    if (enable) begin
      if (retEn) begin
        if (!w_empty) begin
          w_pcNext    = r_stack[w_topIdx];
          w_depthNext = r_depth - 1'b1;
        end else begin
          // Empty return degrades to a plain step but never raises wrapped.
          w_pcNext       = w_sum[WIDTH-1:0];
          w_setUnderflow = 1'b1;
        end
      end else if (callEn) begin
        w_pcNext = jumpAddr;
        if (!w_full) begin
          w_push      = 1'b1;
          w_depthNext = r_depth + 1'b1;
        end else begin
          w_setOverflow = 1'b1;
        end
      end else if (jumpEn) begin
        w_pcNext = jumpAddr;
      end else if (branchEn) begin
        w_pcNext = w_branchTarget;
      end else begin
        w_pcNext   = w_sum[WIDTH-1:0];
        w_wrapNext = w_sum[WIDTH];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc        <= c_RESET_VEC;
      r_depth     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_wrapped   <= 1'b0;
    end else begin
      r_pc        <= w_pcNext;
      r_depth     <= w_depthNext;
      r_overflow  <= r_overflow  | w_setOverflow;
      r_underflow <= r_underflow | w_setUnderflow;
      r_wrapped   <= w_wrapNext;
    end
  end

  // The return address is pcCount+STEP of the call cycle, i.e. the low bits
  // of the step sum.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_stack[w_pushIdx] <= w_sum[WIDTH-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign pcCount    = r_pc;
  assign pcPlusStep = w_sum[WIDTH-1:0];
  assign stackDepth = r_depth;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;
  assign wrapped    = r_wrapped;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer (WIDTH=8, STEP=1,
//                RESET_VEC=0x10, DEPTH=4). Directed scenarios followed by a
//                randomized run, all checked against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam int W     = 8;
  localparam int STEP  = 1;
  localparam int RVEC  = 'h10;
  localparam int DEPTH = 4;
  localparam int MOD   = 1 << W;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable;
  logic           jumpEn;
  logic [W-1:0]   jumpAddr;
  logic           branchEn;
  logic [W-1:0]   branchOff;
  logic           callEn;
  logic           retEn;
  logic [W-1:0]   pcCount;
  logic [W-1:0]   pcPlusStep;
  logic [$clog2(DEPTH):0] stackDepth;
  logic           overflow;
  logic           underflow;
  logic           wrapped;

  pc_sequencer #(
    .WIDTH(W), .STEP(STEP), .RESET_VEC(RVEC), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .jumpEn(jumpEn), .jumpAddr(jumpAddr),
    .branchEn(branchEn), .branchOff(branchOff),
    .callEn(callEn), .retEn(retEn),
    .pcCount(pcCount), .pcPlusStep(pcPlusStep), .stackDepth(stackDepth),
    .overflow(overflow), .underflow(underflow), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  // Reference model: PC as an integer, return stack as a queue.
  int  mPc;
  int  mStack[$];
  bit  mOvf, mUdf, mWrap;

  int  nChecks = 0;
  int  nPass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic checkAll(input string tag);
    check({tag, ".pcCount"},    32'(pcCount),    32'(mPc));
    check({tag, ".pcPlusStep"}, 32'(pcPlusStep), 32'((mPc + STEP) % MOD));
    check({tag, ".stackDepth"}, 32'(stackDepth), 32'(mStack.size()));
    check({tag, ".overflow"},   32'(overflow),   32'(mOvf));
    check({tag, ".underflow"},  32'(underflow),  32'(mUdf));
    check({tag, ".wrapped"},    32'(wrapped),    32'(mWrap));
  endtask

  task automatic modelReset();
    mPc = RVEC;
    mStack.delete();
    mOvf = 0; mUdf = 0; mWrap = 0;
  endtask

  // Drive one cycle of commands, advance the model, then check after the edge.
  task automatic cycle(input string tag, input bit en, input bit r, input bit c,
                       input bit j, input bit b, input int addr, input int off);
    int sum;
    enable = en; retEn = r; callEn = c; jumpEn = j; branchEn = b;
    jumpAddr = W'(addr); branchOff = W'(off);
    sum   = mPc + STEP;
    mWrap = 0;
    if (en) begin
      if (r) begin
        if (mStack.size() > 0) mPc = mStack.pop_back();
        else begin mPc = sum % MOD; mUdf = 1; end
      end else if (c) begin
        if (mStack.size() < DEPTH) mStack.push_back(sum % MOD);
        else mOvf = 1;
        mPc = addr % MOD;
      end else if (j) begin
        mPc = addr % MOD;
      end else if (b) begin
        mPc = (mPc + (off % MOD)) % MOD;
      end else begin
        mWrap = (sum >= MOD);
        mPc   = sum % MOD;
      end
    end
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  task automatic step(input string tag);
    cycle(tag, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic jump(input string tag, input int addr);
    cycle(tag, 1, 0, 0, 1, 0, addr, 0);
  endtask

  task automatic call(input string tag, input int addr);
    cycle(tag, 1, 0, 1, 0, 0, addr, 0);
  endtask

  task automatic ret(input string tag);
    cycle(tag, 1, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // ---------------- Reset state ----------------
    reset = 1'b1; enable = 0; jumpEn = 0; branchEn = 0; callEn = 0; retEn = 0;
    jumpAddr = '0; branchOff = '0;
    modelReset();
    #1;
    checkAll("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    checkAll("resetRelease");

    // ---------------- Sequential step ----------------
    step("step1"); step("step2"); step("step3");
    check("step3.abs", 32'(pcCount), 32'h13);

    // Asynchronous reset mid-cycle
    #2 reset = 1'b1;
    #1;
    modelReset();
    checkAll("asyncReset");
    check("asyncReset.abs", 32'(pcCount), 32'h10);
    #1 reset = 1'b0;

    // ---------------- Wrap ----------------
    jump("jumpFE", 'hFE);
    step("toFF");
    check("toFF.abs", 32'(pcCount), 32'hFF);
    step("wrap0");
    check("wrap0.pulse", 32'(wrapped), 32'h1);
    step("afterWrap");
    check("afterWrap.pulse", 32'(wrapped), 32'h0);
    jump("jumpF0", 'hF0);
    cycle("branch7F", 1, 0, 0, 0, 1, 0, 'h7F);
    check("branch7F.abs", 32'(pcCount), 32'h6F);
    cycle("branchNeg", 1, 0, 0, 0, 1, 0, 'hF0);  // -16

    // ---------------- Priority ----------------
    jump("jump20", 'h20);
    cycle("prioCall", 1, 0, 1, 1, 1, 'h40, 'h05);
    check("prioCall.abs", 32'(pcCount), 32'h40);
    cycle("stallAll", 0, 1, 1, 1, 1, 'h99, 'h33);
    ret("prioRet");
    check("prioRet.top", 32'(pcCount), 32'h21);

    // ---------------- Call/return nesting ----------------
    jump("jump00", 'h00);
    call("call50", 'h50); call("call60", 'h60); call("call70", 'h70);
    ret("ret1");
    check("ret1.abs", 32'(pcCount), 32'h61);
    ret("ret2"); ret("ret3");
    check("ret3.abs", 32'(pcCount), 32'h01);

    // ---------------- Stack boundaries ----------------
    for (int i = 0; i < 5; i++) call($sformatf("fill%0d", i), 'h80 + 8 * i);
    check("full.overflow", 32'(overflow), 32'h1);
    check("full.depth", 32'(stackDepth), 32'h4);
    for (int i = 0; i < 5; i++) ret($sformatf("drain%0d", i));
    check("empty.underflow", 32'(underflow), 32'h1);
    step("stickyStep");
    check("sticky.overflow", 32'(overflow), 32'h1);

    // ---------------- Randomized ----------------
    @(negedge clk);
    reset = 1'b1; #1; modelReset(); checkAll("randReset");
    reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      cycle("rand",
            ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0),
            int'($urandom_range(0, MOD - 1)),
            int'($urandom_range(0, MOD - 1)));
    end

    // Final reset must clear sticky flags.
    @(negedge clk);
    reset = 1'b1; #1; modelReset(); checkAll("finalReset");
    reset = 1'b0;

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the team's CPU datapath, the next generation of the fixed 8-bit PC incrementer. It holds the PC register and computes its next value: sequential step, absolute jump, signed relative branch, and call/return through a small internal return-address stack. It sits between the control unit (commands) and instruction memory (address).

## Interface

Parameters:
- WIDTH, 8, PC and address width in bits (2..32)
- STEP, 1, sequential increment added to the PC
- RESET_VEC, 0, PC value loaded on reset
- DEPTH, 4, return-stack entries (power of two, 2..16)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  1 = PC may advance this cycle; 0 = hold everything (stall)
- jumpEn  in  1  absolute jump to jumpAddr
- jumpAddr  in  WIDTH  absolute target
- branchEn  in  1  relative branch
- branchOff  in  WIDTH  two's-complement offset added to pcCount
- callEn  in  1  push return address, jump to jumpAddr
- retEn  in  1  pop return address into PC
- pcCount  out  WIDTH  current PC (registered)
- pcPlusStep  out  WIDTH  pcCount + STEP (combinational)
- stackDepth  out  clog2(DEPTH)+1  valid entries on the return stack
- overflow  out  1  sticky: a call was issued with the stack full
- underflow  out  1  sticky: a return was issued with the stack empty
- wrapped  out  1  one-cycle pulse: last sequential step wrapped past all-ones

## Operation

- Reset (asynchronous): pcCount = RESET_VEC, stackDepth = 0, overflow = underflow = wrapped = 0, stack contents don't-care.
- enable = 0: pcCount, stack, and flags hold; wrapped = 0. All commands are ignored.
- enable = 1: the highest-priority asserted command wins; the others are ignored. Priority order: retEn > callEn > jumpEn > branchEn > step.
  - ret, stack non-empty: pcCount = top entry; stackDepth decrements.
  - ret, stack empty: pcCount = pcCount + STEP; underflow set.
  - call, stack not full: push pcCount + STEP; pcCount = jumpAddr; stackDepth increments.
  - call, stack full: no push, stack unchanged; overflow set; pcCount = jumpAddr.
  - jump: pcCount = jumpAddr.
  - branch: pcCount = pcCount + branchOff, modulo 2^WIDTH.
  - step (no command asserted): pcCount = pcCount + STEP, modulo 2^WIDTH.
- Arithmetic: all sums are WIDTH bits and the carry is discarded.
- wrapped: asserted for one cycle after a step whose WIDTH+1-bit sum carried out. It is not asserted for branch, ret-underflow, or jump.
- overflow and underflow are cleared only by reset.
- Stack is LIFO. Return addresses stored are pcCount + STEP evaluated in the call cycle.

## Timing

- All state updates on the rising clk edge; command inputs are sampled at that edge.
- Latency: a command sampled at edge N is visible on pcCount after edge N.
- pcPlusStep follows pcCount combinationally within the same cycle.
- Back-to-back call/ret on consecutive cycles is supported with no bubble. A ret immediately after a call returns the address just pushed.
- Reset asserted mid-sequence clears the state immediately, independent of clk. The first command after reset deasserts is taken at the next rising edge.
- Flags and stackDepth are registered, updated on the same edge as pcCount.

## Test plan

- Reset/step (WIDTH=8, STEP=1, RESET_VEC=0x10): release reset, enable=1 for 3 cycles -> pcCount 0x10, 0x11, 0x12, 0x13; pcPlusStep is always pcCount+1. Assert reset mid-cycle -> pcCount is 0x10 immediately.
- Wrap: jump to 0xFE, then 2 steps -> pcCount 0xFF, then 0x00 with wrapped=1 for exactly one cycle. Branch 0x7F from 0xF0 -> 0x6F with wrapped=0.
- Priority: at pcCount=0x20, assert jumpEn (0x40), branchEn (0x05) and callEn together -> pcCount 0x40, stackDepth 1, top entry 0x21. enable=0 with all commands asserted -> no change.
- Call/return nesting: call 0x50 from 0x00, call 0x60, call 0x70, ret, ret, ret -> pcCount 0x70, 0x61, 0x51, 0x01; stackDepth returns to 0; no flags set.
- Stack boundaries (DEPTH=4): 5 consecutive calls -> the 5th jumps but does not push, overflow=1, stackDepth=4. Then 5 rets -> 4 pop correctly, the 5th steps with underflow=1. Both flags stay set until reset.
